// File: rtl/gcd_pkg.sv
// Shared types for the GCD operand sequencer: FSM states, default sizing and
// the result record returned to the consumer.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam int GCD_NBITS      = 8;
  localparam int GCD_MAX_CYCLES = 300;
  localparam int GCD_CNT_BITS   = $clog2(GCD_MAX_CYCLES + 1);

  typedef struct packed {
    logic [GCD_NBITS-1:0]    gcd;
    logic [GCD_CNT_BITS-1:0] cycles;
    logic                    timeout;
  } gcd_result_t;

endpackage

// File: rtl/gcd_sequencer.sv
// Operand sequencer for the subtraction-GCD core: accepts a pair, loads and runs
// the core, and returns the captured result with run-cycle count and timeout flag.
module gcd_sequencer
  import gcd_pkg::*;
#(
  parameter int NBits     = GCD_NBITS,
  parameter int MaxCycles = GCD_MAX_CYCLES,
  parameter int CntBits   = $clog2(MaxCycles + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NBits-1:0]   in_x,
  input  logic [NBits-1:0]   in_y,
  output logic [NBits-1:0]   gcd_xi,
  output logic [NBits-1:0]   gcd_yi,
  output logic               gcd_start,
  input  logic [NBits-1:0]   gcd_xo,
  input  logic               gcd_rdy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NBits-1:0]   out_gcd,
  output logic [CntBits-1:0] out_cycles,
  output logic               out_timeout,
  output logic               busy
);

  localparam logic [CntBits-1:0] MAX_CNT = CntBits'(MaxCycles);

  seq_state_e         state, state_nxt;
  logic [NBits-1:0]   op_x, op_y;
  logic [CntBits-1:0] cnt, cnt_inc;
  logic               accept;
  logic               run_hit_max;

  assign cnt_inc     = cnt + CntBits'(1);
  assign run_hit_max = (cnt_inc == MAX_CNT);
  assign accept      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN:  if (gcd_rdy || run_hit_max) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, run counter and result capture; rdy wins over timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_x        <= '0;
      op_y        <= '0;
      cnt         <= '0;
      out_gcd     <= '0;
      out_cycles  <= '0;
      out_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_x <= in_x;
            op_y <= in_y;
          end
        end
        LOAD: cnt <= '0;
        RUN: begin
          cnt <= cnt_inc;
          if (gcd_rdy) begin
            out_gcd     <= gcd_xo;
            out_cycles  <= cnt_inc;
            out_timeout <= 1'b0;
          end else if (run_hit_max) begin
            out_gcd     <= '0;
            out_cycles  <= MAX_CNT;
            out_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state only; rst gating keeps handshakes quiet in reset.
  assign gcd_xi    = op_x;
  assign gcd_yi    = op_y;
  assign gcd_start = (state == RUN);
  assign out_valid = (state == DONE);
  assign in_ready  = rst && (state == IDLE);
  assign busy      = rst && (state != IDLE);

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: drives it against a behavioural subtraction-GCD core,
// plus a second instance with rdy tied low and a short run limit.
module tb_gcd_sequencer;
  import gcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_x = '0, in_y = '0;
  logic [7:0] gcd_xi, gcd_yi, gcd_xo;
  logic       gcd_start, gcd_rdy;
  logic       out_valid, out_ready = 1'b1;
  logic [7:0] out_gcd;
  logic [8:0] out_cycles;
  logic       out_timeout, busy;

  gcd_sequencer #(.NBits(8), .MaxCycles(300)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .gcd_xi(gcd_xi), .gcd_yi(gcd_yi),
    .gcd_start(gcd_start), .gcd_xo(gcd_xo), .gcd_rdy(gcd_rdy),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_cycles(out_cycles), .out_timeout(out_timeout), .busy(busy)
  );

  // Behavioural core: load while start low, one subtract step per start-high edge.
  logic [7:0] cx, cy;
  logic       core_rdy = 1'b0;
  logic [7:0] core_xo = '0;
  assign gcd_xo  = core_xo;
  assign gcd_rdy = core_rdy;
  always @(posedge clk) begin
    if (!gcd_start) begin
      cx <= gcd_xi; cy <= gcd_yi; core_rdy <= 1'b0;
    end else if (!core_rdy) begin
      if (cx == 0 || cy == 0) begin core_xo <= '0; core_rdy <= 1'b1; end
      else if (cx == cy)      begin core_xo <= cx; core_rdy <= 1'b1; end
      else if (cx > cy) cx <= cx - cy;
      else              cy <= cy - cx;
    end
  end

  // Second instance: core never answers, run limit of 4.
  logic       t_in_valid = 1'b0, t_in_ready;
  logic [7:0] t_in_x = '0, t_in_y = '0, t_xi, t_yi;
  logic [7:0] t_xo = '0;
  logic       t_rdy = 1'b0;
  logic       t_start, t_out_valid, t_out_ready = 1'b1;
  logic [7:0] t_out_gcd;
  logic [2:0] t_out_cycles;
  logic       t_out_timeout, t_busy;

  gcd_sequencer #(.NBits(8), .MaxCycles(4)) dut_to (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_x(t_in_x), .in_y(t_in_y), .gcd_xi(t_xi), .gcd_yi(t_yi),
    .gcd_start(t_start), .gcd_xo(t_xo), .gcd_rdy(t_rdy),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_gcd(t_out_gcd),
    .out_cycles(t_out_cycles), .out_timeout(t_out_timeout), .busy(t_busy)
  );

  int start_hi = 0, t_start_hi = 0;
  always @(negedge clk) begin
    if (gcd_start) start_hi++;
    if (t_start)   t_start_hi++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    if (a == 0 || b == 0) return 0;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  // Run cycles = subtraction steps to reach equality (or zero), plus the
  // detecting edge, plus the capture cycle.
  function automatic int ref_cycles(input int a, input int b);
    int s = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a > b) a -= b; else b -= a;
      s++;
    end
    return s + 2;
  endfunction

  int snap;

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    in_x = x; in_y = y; in_valid = 1'b1;
    while (!in_ready && n < 1000) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("accept_wait", 0, 1); return; end
    @(posedge clk);
    @(negedge clk);
    snap = start_hi;
    chk("load_start_low", gcd_start, 0);
    chk("load_busy", busy, 1);
    chk("load_xi", gcd_xi, x);
    chk("load_yi", gcd_yi, y);
  endtask

  task automatic collect(input int eg, input int ec, input int hold);
    int n = 0;
    if (hold > 0) out_ready = 1'b0;
    while (!out_valid && n < 1000) begin @(negedge clk); n++; end
    if (!out_valid) begin chk("result_wait", 0, 1); out_ready = 1'b1; return; end
    chk("res_gcd", out_gcd, eg);
    chk("res_cycles", out_cycles, ec);
    chk("res_timeout", out_timeout, 0);
    chk("start_hi_cycles", start_hi - snap, ec);
    chk("done_start_low", gcd_start, 0);
    if (hold > 0) begin
      in_x = 8'd99; in_y = 8'd33; in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_gcd", out_gcd, eg);
        chk("hold_cycles", out_cycles, ec);
        chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("post_valid_low", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] g;
    int         cyc;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'd12,  8'd18,  8'd6, 4};
    tbl[1] = '{8'd0,   8'd5,   8'd0, 2};
    tbl[2] = '{8'd5,   8'd0,   8'd0, 2};
    tbl[3] = '{8'd7,   8'd7,   8'd7, 2};
    tbl[4] = '{8'd9,   8'd6,   8'd3, 4};
    tbl[5] = '{8'd200, 8'd8,   8'd8, 26};
    tbl[6] = '{8'd1,   8'd255, 8'd1, 256};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_start", gcd_start, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_out_cycles", out_cycles, 0);
    chk("rst_timeout", out_timeout, 0);
    chk("rst_xi", gcd_xi, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    foreach (tbl[i]) begin
      send(tbl[i].x, tbl[i].y);
      in_valid = 1'b0;
      collect(tbl[i].g, tbl[i].cyc, 0);
    end

    send(8'd21, 8'd14);
    in_valid = 1'b0;
    collect(7, 4, 10);
    chk("hold_no_accept_xi", gcd_xi, 21);

    send(8'd8, 8'd12);  collect(4, 4, 0);
    send(8'd35, 8'd10); collect(5, 6, 0);
    send(8'd7, 8'd7);   in_valid = 1'b0; collect(7, 2, 0);

    begin
      int n = 0;
      t_in_x = 8'd3; t_in_y = 8'd5; t_in_valid = 1'b1;
      while (!t_in_ready && n < 100) begin @(negedge clk); n++; end
      snap = t_start_hi;
      @(posedge clk);
      @(negedge clk);
      t_in_valid = 1'b0;
      n = 0;
      while (!t_out_valid && n < 100) begin @(negedge clk); n++; end
      chk("to_valid", t_out_valid, 1);
      chk("to_flag", t_out_timeout, 1);
      chk("to_gcd", t_out_gcd, 0);
      chk("to_cycles", t_out_cycles, 4);
      chk("to_run_cycles", t_start_hi - snap, 4);
      @(posedge clk);
      @(negedge clk);
      chk("to_post_valid", t_out_valid, 0);
    end

    send(8'd255, 8'd1);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_run_start", gcd_start, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_start", gcd_start, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_idle", in_ready, 1);
    chk("mrst_cycles", out_cycles, 0);
    begin
      int seen = 0;
      repeat (4) begin @(negedge clk); if (out_valid) seen++; end
      chk("mrst_no_result", seen, 0);
    end
    send(8'd9, 8'd6);
    in_valid = 1'b0;
    collect(3, 4, 0);

    for (int i = 0; i < 25; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send(a, b);
      in_valid = 1'b0;
      collect(ref_gcd(a, b), ref_cycles(a, b), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_sequencer.md
Name: gcd_sequencer

Overview:
- Upstream operand sequencer for the subtraction-GCD core.
- Accepts operand pairs on a valid/ready stream and drives the core's xi/yi/start protocol: load phase with start low, then run phase with start high.
- Waits for the core's rdy, captures xo, and returns the result on a valid/ready output stream with a cycle count and a timeout flag.
- Sits between the operand source (testbench or host FSM) and the GCD core. One operation in flight at a time.

Parameters:
- NBits, 8, operand/result width; must match the core's NBits.
- MaxCycles, 300, run-phase cycle limit before the operation is aborted as timed out.
- CntBits, $clog2(MaxCycles+1), width of the run-cycle counter and of out_cycles.

Ports:
- clk  in  1  single clock, posedge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- in_valid  in  1  operand pair present.
- in_ready  out  1  sequencer can accept a pair.
- in_x  in  NBits  operand x.
- in_y  in  NBits  operand y.
- gcd_xi  out  NBits  to core xi.
- gcd_yi  out  NBits  to core yi.
- gcd_start  out  1  to core start.
- gcd_xo  in  NBits  from core xo.
- gcd_rdy  in  1  from core rdy.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_gcd  out  NBits  captured result; 0 on timeout.
- out_cycles  out  CntBits  run-phase cycles consumed.
- out_timeout  out  1  result aborted by timeout.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from state only; no combinational path from input to output.
- Reset (rst == 0 at a posedge):
  - state = IDLE.
  - Operand registers, out_gcd, out_cycles, out_timeout, and the counter are all 0.
  - gcd_start = 0, out_valid = 0.
  - While rst is low, in_ready = 0 and busy = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch in_x/in_y into the operand registers and go to LOAD.
- LOAD:
  - Lasts exactly 1 cycle.
  - gcd_xi/gcd_yi = operand registers, held stable from LOAD until the next accept.
  - gcd_start = 0, so the core loads x/y and clears rdy.
  - Clear the counter, then go to RUN.
- RUN:
  - gcd_start = 1. The counter increments every RUN cycle, including the capture cycle.
  - If gcd_rdy == 1: out_gcd <= gcd_xo, out_cycles <= counter+1, out_timeout <= 0, go to DONE.
  - Else if counter+1 == MaxCycles: out_gcd <= 0, out_cycles <= MaxCycles, out_timeout <= 1, go to DONE.
  - rdy takes priority over timeout when both occur in the same cycle.
  - gcd_rdy seen outside RUN is ignored.
- DONE:
  - gcd_start = 0 and out_valid = 1.
  - out_gcd, out_cycles, and out_timeout stay stable while out_valid && !out_ready.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - in_ready = 0, so there is no accept in the same cycle as the result handshake.
- Latency:
  - Accept at edge T; LOAD cycle; RUN from T+2.
  - For a core that raises rdy after k run edges, the result is captured after k+1 RUN cycles and out_valid is high 1 cycle after capture.
- Widths: operands are passed through unmodified. The counter saturates logic-free because it is bounded by MaxCycles.
- Reset mid-operation: immediate return to IDLE, gcd_start = 0, any pending result is discarded, and no out_valid pulse.
- Zero operand: the core returns 0 with rdy; this is forwarded as a normal result with out_timeout = 0.

Decomposition:
- Shared package gcd_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - the default NBits;
  - MaxCycles default;
  - the result struct {gcd, cycles, timeout}.
- No sub-module is required; the counter and FSM live in one module.
- Top-level integration instantiates the sequencer and the GCD core side by side with matching NBits.

Test Plan:
- (12,18), out_ready = 1, real core → out_gcd = 6, out_cycles = 4, out_timeout = 0; out_valid high 1 cycle; in_ready high again the next cycle.
- (0,5) → out_gcd = 0, out_timeout = 0; core start high for exactly one run-through, then dropped in DONE.
- (21,14) with out_ready held low 10 cycles → out_valid and out_gcd = 7 stable for all 10 cycles; in_ready stays 0; in_valid presented meanwhile is not accepted.
- Stub core with rdy tied 0, MaxCycles = 4 → after exactly 4 RUN cycles, out_timeout = 1, out_gcd = 0, out_cycles = 4.
- rst = 0 for one cycle during RUN of (255,1) → next cycle: state IDLE, gcd_start = 0, out_valid = 0. A following pair (9,6) yields 3.
- Back-to-back pairs (8,12),(35,10),(7,7) with in_valid continuously high → results 4, 5, 7 in order, each preceded by one LOAD cycle with gcd_start = 0.
